// File: rtl/abr_masked_arith_accumulator_pkg.sv
// Shared types for the masked arithmetic accumulator: FSM states and the share-pair type.
// Every accumulator file imports this package; the share-pair width follows ABR_WIDTH.
package abr_params_pkg;

  localparam int ABR_WIDTH     = 8;
  localparam int ABR_NUM_COEFF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } abr_state_e;

  // First-order arithmetic masking: value = s0 + s1 mod 2^ABR_WIDTH
  typedef struct packed {
    logic [ABR_WIDTH-1:0] s0;
    logic [ABR_WIDTH-1:0] s1;
  } abr_share_pair_t;

endpackage

// File: rtl/abr_masked_arith_accumulator_if.sv
// Stream interface of the masked accumulator: B2A-format coefficient input and masked-sum output.
// The master side drives coefficients and takes results; the slave side is the accumulator.
interface abr_masked_arith_accumulator_if
  import abr_params_pkg::*;
#(
  parameter int WIDTH = ABR_WIDTH
);
  logic                  zeroize;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0][1:0] in_arith;
  logic [WIDTH-1:0]      rnd;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_share0;
  logic [WIDTH-1:0]      out_share1;
  logic                  busy;

  modport master (
    output zeroize, in_valid, in_arith, rnd, out_ready,
    input  in_ready, out_valid, out_share0, out_share1, busy
  );

  modport slave (
    input  zeroize, in_valid, in_arith, rnd, out_ready,
    output in_ready, out_valid, out_share0, out_share1, busy
  );
endinterface

// File: rtl/abr_masked_share_add.sv
// Registered single-share accumulator mod 2^WIDTH with clear/load/accumulate controls.
// Clear has priority over load, and load has priority over accumulate.
module abr_masked_share_add
  import abr_params_pkg::*;
#(
  parameter int WIDTH = ABR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_acc,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_sum
);

  logic [WIDTH-1:0] r_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_load) begin
      r_sum <= i_data;
    end else if (i_acc) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/abr_masked_arith_accumulator.sv
// Accumulates arithmetic-masked coefficients share-wise over NUM_COEFF inputs and emits
// the refreshed masked sum (accA + rnd, accR - rnd) without ever recombining the shares.
module abr_masked_arith_accumulator
  import abr_params_pkg::*;
#(
  parameter int WIDTH     = ABR_WIDTH,
  parameter int NUM_COEFF = ABR_NUM_COEFF
) (
  input  logic                           clk,
  input  logic                           rst,
  abr_masked_arith_accumulator_if.slave  bus
);

  localparam int                CNT_W    = $clog2(NUM_COEFF);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_COEFF - 1);

  abr_state_e            r_state;
  abr_state_e            w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_rnd;

  logic [1:0][WIDTH-1:0] w_in_sh;
  logic [1:0][WIDTH-1:0] w_acc_sh;
  abr_share_pair_t       w_out;

  logic w_in_ready;
  logic w_out_valid;
  logic w_busy;
  logic w_accept;
  logic w_last;
  logic w_clear;
  logic w_load;
  logic w_acc_en;

  // Split the B2A bit-interleaved input into share A (index 0) and share r (index 1)
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_unpack
      assign w_in_sh[0][gi] = bus.in_arith[gi][0];
      assign w_in_sh[1][gi] = bus.in_arith[gi][1];
    end
  endgenerate

  assign w_accept = bus.in_valid & w_in_ready & ~bus.zeroize;
  assign w_last   = (r_state == ACCUM) && (r_cnt == LAST_CNT);

  assign w_clear  = bus.zeroize | ((r_state == DONE) & bus.out_ready);
  assign w_load   = w_accept & (r_state == IDLE);
  assign w_acc_en = w_accept & (r_state == ACCUM);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_share
      abr_masked_share_add #(
        .WIDTH (WIDTH)
      ) u_share_add (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_load  (w_load),
        .i_acc   (w_acc_en),
        .i_data  (w_in_sh[gi]),
        .o_sum   (w_acc_sh[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.zeroize) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_accept) w_state_next = ACCUM;
        ACCUM:   if (w_accept && w_last) w_state_next = DONE;
        DONE:    if (bus.out_ready) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_in_ready  = (r_state != DONE);
    w_out_valid = (r_state == DONE);
    w_busy      = (r_cnt != '0) || (r_state == DONE);
  end

  // Refresh randomness is captured only on the final accept of a block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_rnd <= '0;
    end else if (bus.zeroize) begin
      r_cnt <= '0;
      r_rnd <= '0;
    end else if (w_load) begin
      r_cnt <= CNT_W'(1);
    end else if (w_acc_en) begin
      if (w_last) begin
        r_cnt <= '0;
        r_rnd <= bus.rnd;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if ((r_state == DONE) && bus.out_ready) begin
      r_rnd <= '0;
    end
  end

  // Outputs derive only from registers that hold still for the whole DONE state
  always_comb begin
    w_out = '0;
    if (r_state == DONE) begin
      w_out.s0 = w_acc_sh[0] + r_rnd;
      w_out.s1 = w_acc_sh[1] - r_rnd;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.busy       = w_busy;
  assign bus.out_share0 = w_out.s0;
  assign bus.out_share1 = w_out.s1;

endmodule

// File: tb/tb_abr_masked_arith_accumulator.sv
// Directed and randomized bench for the masked accumulator, checked against a plain-arithmetic model.
module tb_abr_masked_arith_accumulator;
  import abr_params_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  abr_masked_arith_accumulator_if #(.WIDTH(8)) bus ();

  abr_masked_arith_accumulator #(
    .WIDTH     (8),
    .NUM_COEFF (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] blk_a [4];
  logic [7:0] blk_r [4];
  logic [7:0] last_s0;
  bit         seen_s0 [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_arith(input logic [7:0] a, input logic [7:0] r);
    for (int i = 0; i < 8; i++) begin
      bus.in_arith[i][0] = a[i];
      bus.in_arith[i][1] = r[i];
    end
  endtask

  // Model: masked shares are the independent share sums shifted by +rnd / -rnd
  task automatic ref_block(input logic [7:0] rnd_v, output logic [7:0] e0,
                           output logic [7:0] e1, output logic [7:0] ex);
    int sa, sr, sx;
    sa = 0; sr = 0; sx = 0;
    for (int i = 0; i < 4; i++) begin
      sa += int'(blk_a[i]);
      sr += int'(blk_r[i]);
      sx += int'(blk_a[i]) + int'(blk_r[i]);
    end
    e0 = 8'((sa + int'(rnd_v)) % 256);
    e1 = 8'((((sr - int'(rnd_v)) % 256) + 256) % 256);
    ex = 8'(sx % 256);
  endtask

  // Called at a negedge; presents one coefficient for exactly one rising edge
  task automatic send(input string tag, input logic [7:0] a, input logic [7:0] r,
                      input logic [7:0] rnd_v);
    set_arith(a, r);
    bus.rnd      = rnd_v;
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    set_arith(8'($urandom), 8'($urandom));
  endtask

  // gaps[2i+:2] idle cycles precede coefficient i; hold = cycles of out_ready backpressure
  task automatic run_block(input string tag, input logic [7:0] rnd_v,
                           input logic [7:0] gaps, input int hold);
    logic [7:0] e0, e1, ex, sum8;
    ref_block(rnd_v, e0, e1, ex);
    for (int i = 0; i < 4; i++) begin
      repeat (int'(gaps[2*i +: 2])) begin
        bus.in_valid = 1'b0;
        set_arith(8'($urandom), 8'($urandom));
        @(negedge clk);
        if (i > 0) chk({tag, "_gap_busy"}, 32'(bus.busy), 32'd1);
      end
      send(tag, blk_a[i], blk_r[i], (i == 3) ? rnd_v : 8'($urandom));
      if (i < 3) begin
        chk({tag, "_valid_early"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      end
    end
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_share0"}, 32'(bus.out_share0), 32'(e0));
    chk({tag, "_share1"}, 32'(bus.out_share1), 32'(e1));
    sum8 = bus.out_share0 + bus.out_share1;
    chk({tag, "_unmasked"}, 32'(sum8), 32'(ex));
    last_s0 = bus.out_share0;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      set_arith(8'($urandom), 8'($urandom));
      @(negedge clk);
      chk({tag, "_bp_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_bp_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_bp_share0"}, 32'(bus.out_share0), 32'(e0));
      chk({tag, "_bp_share1"}, 32'(bus.out_share1), 32'(e1));
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    chk({tag, "_rel_in_ready"}, 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_post_share0"}, 32'(bus.out_share0), 32'd0);
    $display("block %s rnd=%02h share0=%02h share1=%02h sum=%02h", tag, rnd_v, e0, e1, ex);
  endtask

  task automatic load_block(input logic [7:0] a0, input logic [7:0] r0, input logic [7:0] a1,
                            input logic [7:0] r1, input logic [7:0] a2, input logic [7:0] r2,
                            input logic [7:0] a3, input logic [7:0] r3);
    blk_a[0] = a0; blk_r[0] = r0; blk_a[1] = a1; blk_r[1] = r1;
    blk_a[2] = a2; blk_r[2] = r2; blk_a[3] = a3; blk_r[3] = r3;
  endtask

  task automatic random_block();
    for (int i = 0; i < 4; i++) begin
      blk_a[i] = 8'($urandom);
      blk_r[i] = 8'($urandom);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_share0"}, 32'(bus.out_share0), 32'd0);
    chk({tag, "_share1"}, 32'(bus.out_share1), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int distinct;
    rst           = 1'b1;
    bus.zeroize   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.rnd       = '0;
    set_arith(8'h00, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cleared("reset");

    // Basic: x = 10,20,30,40, rnd 0x33 -> 103 / 253, sum 100
    load_block(8'd5, 8'd5, 8'd176, 8'd100, 8'd86, 8'd200, 8'd41, 8'd255);
    run_block("basic", 8'h33, 8'h00, 0);

    load_block(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_block("wrap", 8'h00, 8'h00, 0);

    random_block();
    run_block("backpressure", 8'($urandom), 8'h00, 5);
    load_block(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    run_block("after_bp", 8'h10, 8'h00, 0);

    // in_valid pattern 1,0,0,1,1,0,1
    load_block(8'd5, 8'd5, 8'd176, 8'd100, 8'd86, 8'd200, 8'd41, 8'd255);
    run_block("gapped", 8'h33, 8'b01_00_10_00, 0);

    // Zeroize after two accepts, asserted together with a valid coefficient
    send("zpre", 8'hAA, 8'h55, 8'h00);
    send("zpre", 8'h11, 8'h22, 8'h00);
    bus.zeroize  = 1'b1;
    bus.in_valid = 1'b1;
    set_arith(8'h77, 8'h88);
    @(negedge clk);
    bus.zeroize  = 1'b0;
    bus.in_valid = 1'b0;
    check_cleared("zeroize");
    load_block(8'd9, 8'd1, 8'd19, 8'd1, 8'd29, 8'd1, 8'd39, 8'd1);
    run_block("after_zeroize", 8'hC4, 8'h00, 0);

    // Asynchronous reset between edges in the middle of ACCUM
    send("rpre", 8'hF0, 8'h0F, 8'h00);
    send("rpre", 8'h12, 8'h34, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    random_block();
    run_block("after_rst", 8'($urandom), 8'h00, 0);

    for (int b = 0; b < 24; b++) begin
      random_block();
      run_block("random", 8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end

    // Every refresh value on one block: share0 must hit all 256 values, sum unchanged
    random_block();
    for (int v = 0; v < 256; v++) seen_s0[v] = 1'b0;
    for (int v = 0; v < 256; v++) begin
      run_block("rnd_sweep", 8'(v), 8'h00, 0);
      seen_s0[last_s0] = 1'b1;
    end
    distinct = 0;
    for (int v = 0; v < 256; v++) if (seen_s0[v]) distinct++;
    chk("rnd_sweep_distinct_share0", 32'(distinct), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
